// File: rtl/hall_spin_demod.sv
// rtl/hall_spin_demod.sv - spinning-current Hall sequencer and chopping demodulator
module hall_spin_demod #(
   parameter int ADC_W   = 12,
   parameter int SETTLE  = 8,
   parameter int TIMEOUT = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    clr_err,
   output logic [1:0]              afe_phase,
   output logic                    afe_phase_update,
   output logic                    adc_start,
   input  logic                    adc_done,
   input  logic [ADC_W-1:0]        adc_data_a,
   input  logic [ADC_W-1:0]        adc_data_b,
   output logic signed [ADC_W+1:0] meas_a,
   output logic signed [ADC_W+1:0] meas_b,
   output logic                    meas_valid,
   output logic                    busy,
   output logic                    adc_timeout
);

   // Accumulator width: two guard bits absorb four full-scale samples.
   localparam int AW = ADC_W + 2;
   // Settle counter holds SETTLE-1 down to 0; wait counter holds 0 up to TIMEOUT-1.
   localparam int SW = (SETTLE  > 1) ? $clog2(SETTLE)  : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UPDATE,
      S_SETTLE,
      S_START,
      S_WAIT
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           phase_q, phase_d;
   logic [1:0]           afe_phase_q, afe_phase_d;
   logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
   logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
   logic signed [AW-1:0] acc_a_q, acc_a_d;
   logic signed [AW-1:0] acc_b_q, acc_b_d;
   logic signed [AW-1:0] meas_a_q, meas_a_d;
   logic signed [AW-1:0] meas_b_q, meas_b_d;
   logic                 meas_valid_q, meas_valid_d;
   logic                 timeout_q, timeout_d;

   logic                 timeout_set;
   logic                 abort_frame;
   logic                 restart_frame;

   logic signed [AW-1:0] ext_a, ext_b;
   logic signed [AW-1:0] sum_a, sum_b;

   // Sign-extend the raw samples and apply the chopping sign: odd phases subtract.
   assign ext_a = {{2{adc_data_a[ADC_W-1]}}, adc_data_a};
   assign ext_b = {{2{adc_data_b[ADC_W-1]}}, adc_data_b};
   assign sum_a = phase_q[0] ? (acc_a_q - ext_a) : (acc_a_q + ext_a);
   assign sum_b = phase_q[0] ? (acc_b_q - ext_b) : (acc_b_q + ext_b);

   // Next-state logic: phase sequencing, settle/wait counting, accumulation and abort handling.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      afe_phase_d   = afe_phase_q;
      settle_cnt_d  = settle_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      acc_a_d       = acc_a_q;
      acc_b_d       = acc_b_q;
      meas_a_d      = meas_a_q;
      meas_b_d      = meas_b_q;
      meas_valid_d  = 1'b0;
      timeout_set   = 1'b0;
      abort_frame   = 1'b0;
      restart_frame = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            if (!enable) begin
               abort_frame = 1'b1;
            end else begin
               settle_cnt_d = SW'(SETTLE - 1);
               state_d      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!enable) begin
               abort_frame = 1'b1;
            end else if (settle_cnt_q == '0) begin
               state_d = S_START;
            end else begin
               settle_cnt_d = settle_cnt_q - SW'(1);
            end
         end
         S_START: begin
            if (!enable) begin
               abort_frame = 1'b1;
            end else begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // A frame-completing sample is always published, even if enable falls on that edge.
            if (adc_done && (phase_q == 2'd3)) begin
               meas_a_d      = sum_a;
               meas_b_d      = sum_b;
               meas_valid_d  = 1'b1;
               restart_frame = 1'b1;
            end else if (!adc_done && (wait_cnt_q == WW'(TIMEOUT - 1))) begin
               timeout_set   = 1'b1;
               restart_frame = 1'b1;
            end else if (!enable) begin
               abort_frame = 1'b1;
            end else if (adc_done) begin
               acc_a_d = sum_a;
               acc_b_d = sum_b;
               phase_d = phase_q + 2'd1;
               state_d = S_UPDATE;
            end else begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_frame) begin
         state_d = S_IDLE;
         phase_d = 2'd0;
         acc_a_d = '0;
         acc_b_d = '0;
      end

      if (restart_frame) begin
         state_d = enable ? S_UPDATE : S_IDLE;
         phase_d = 2'd0;
         acc_a_d = '0;
         acc_b_d = '0;
      end

      // The AFE phase register is only loaded on the way into UPDATE, so it holds through aborts.
      if (state_d == S_UPDATE) begin
         afe_phase_d = phase_d;
      end

      // A new timeout takes priority over a simultaneous clear.
      if (timeout_set) begin
         timeout_d = 1'b1;
      end else if (clr_err) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end
   end

   // State, counter, accumulator and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         phase_q      <= 2'd0;
         afe_phase_q  <= 2'd0;
         settle_cnt_q <= '0;
         wait_cnt_q   <= '0;
         acc_a_q      <= '0;
         acc_b_q      <= '0;
         meas_a_q     <= '0;
         meas_b_q     <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         afe_phase_q  <= afe_phase_d;
         settle_cnt_q <= settle_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         acc_a_q      <= acc_a_d;
         acc_b_q      <= acc_b_d;
         meas_a_q     <= meas_a_d;
         meas_b_q     <= meas_b_d;
         meas_valid_q <= meas_valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign afe_phase        = afe_phase_q;
   assign afe_phase_update = (state_q == S_UPDATE);
   assign adc_start        = (state_q == S_START);
   assign busy             = (state_q != S_IDLE);
   assign meas_a           = meas_a_q;
   assign meas_b           = meas_b_q;
   assign meas_valid       = meas_valid_q;
   assign adc_timeout      = timeout_q;

endmodule

// File: tb/tb_hall_spin_demod.sv
// tb/tb_hall_spin_demod.sv - self-checking bench for hall_spin_demod
module tb_hall_spin_demod;

   localparam int ADC_W = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic              clr_err;
   logic [1:0]        afe_phase;
   logic              afe_phase_update;
   logic              adc_start;
   logic              adc_done;
   logic [ADC_W-1:0]  adc_data_a;
   logic [ADC_W-1:0]  adc_data_b;
   logic signed [ADC_W+1:0] meas_a;
   logic signed [ADC_W+1:0] meas_b;
   logic              meas_valid;
   logic              busy;
   logic              adc_timeout;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int mv_count = 0;
   int frames   = 0;
   int exp_a[$];
   int exp_b[$];
   int upd_cyc[$];
   int upd_ph[$];

   hall_spin_demod #(.ADC_W(ADC_W), .SETTLE(8), .TIMEOUT(256)) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .clr_err          (clr_err),
      .afe_phase        (afe_phase),
      .afe_phase_update (afe_phase_update),
      .adc_start        (adc_start),
      .adc_done         (adc_done),
      .adc_data_a       (adc_data_a),
      .adc_data_b       (adc_data_b),
      .meas_a           (meas_a),
      .meas_b           (meas_b),
      .meas_valid       (meas_valid),
      .busy             (busy),
      .adc_timeout      (adc_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Output side of the scoreboard: phase strobes are logged, results are popped and compared.
   always @(negedge clk) begin
      if (!rst) begin
         if (afe_phase_update) begin
            upd_cyc.push_back(cyc);
            upd_ph.push_back(int'(afe_phase));
         end
         if (meas_valid) begin
            mv_count++;
            check("sb_pending", longint'(exp_a.size() != 0), 1);
            if (exp_a.size() != 0) begin
               check("meas_a", meas_a, exp_a.pop_front());
               check("meas_b", meas_b, exp_b.pop_front());
            end
            check("mv_with_update", afe_phase_update, 1);
            check("mv_phase0", afe_phase, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_update();
      int n = 0;
      while (!afe_phase_update && n < 100) begin
         step();
         n++;
      end
      check("wait_update", afe_phase_update, 1);
   endtask

   task automatic wait_start();
      int n = 0;
      while (!adc_start && n < 100) begin
         step();
         n++;
      end
      check("wait_start", adc_start, 1);
   endtask

   // Entered anywhere before the START cycle; answers with a done pulse in WAIT cycle tw.
   task automatic phase_from_start(input int a, input int b, input int tw, input bit spur);
      int n;
      wait_start();
      n = tw;
      if (spur) begin
         adc_done   = 1'b1;
         adc_data_a = 12'h7FF;
         adc_data_b = 12'h7FF;
         step();
         adc_done = 1'b0;
         n = tw - 1;
      end
      repeat (n) step();
      adc_done   = 1'b1;
      adc_data_a = a[ADC_W-1:0];
      adc_data_b = b[ADC_W-1:0];
      step();
      adc_done   = 1'b0;
      adc_data_a = '0;
      adc_data_b = '0;
   endtask

   task automatic run_phase(input int p, input int a, input int b, input int tw, input bit spur);
      wait_update();
      check("phase_idx", afe_phase, p);
      if (spur) begin
         step();
         step();
         adc_done   = 1'b1;
         adc_data_a = 12'h800;
         adc_data_b = 12'h7FF;
         step();
         adc_done   = 1'b0;
      end
      phase_from_start(a, b, tw, spur);
   endtask

   // Input side of the scoreboard: the chopped sum is computed here before driving samples.
   task automatic do_frame(input int a[4], input int b[4], input int tw, input bit spur);
      int ea = 0;
      int eb = 0;
      for (int p = 0; p < 4; p++) begin
         if (p % 2 == 1) begin
            ea -= a[p];
            eb -= b[p];
         end else begin
            ea += a[p];
            eb += b[p];
         end
      end
      exp_a.push_back(ea);
      exp_b.push_back(eb);
      frames++;
      for (int p = 0; p < 4; p++) run_phase(p, a[p], b[p], tw, spur);
   endtask

   task automatic hang(input int p, input bit clr, input int pre);
      wait_update();
      check("hang_phase", afe_phase, p);
      wait_start();
      repeat (256) step();
      check("to_before_limit", adc_timeout, pre);
      if (clr) clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("to_set", adc_timeout, 1);
      check("to_no_mv", meas_valid, 0);
      check("to_restart_upd", afe_phase_update, 1);
      check("to_restart_ph0", afe_phase, 0);
   endtask

   initial begin
      int ra[4];
      int rb[4];
      int fa[4];
      int fb[4];
      int ta[4];
      int tb[4];
      int mv_before;

      ra = '{1000, -900, 1010, -890};
      rb = '{-50, 150, -60, 140};
      fa = '{2047, -2048, 2047, -2048};
      fb = '{-2048, 2047, -2048, 2047};
      ta = '{300, -200, 100, -50};
      tb = '{-7, 7, -7, 7};

      rst        = 1'b1;
      enable     = 1'b0;
      clr_err    = 1'b0;
      adc_done   = 1'b0;
      adc_data_a = '0;
      adc_data_b = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      check("rst_afe_phase", afe_phase, 0);
      check("rst_update", afe_phase_update, 0);
      check("rst_start", adc_start, 0);
      check("rst_meas_a", meas_a, 0);
      check("rst_meas_b", meas_b, 0);
      check("rst_meas_valid", meas_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", adc_timeout, 0);

      // Basic frame with strobe spacing.
      upd_cyc.delete();
      upd_ph.delete();
      enable = 1'b1;
      do_frame(ra, rb, 5, 1'b0);
      @(negedge clk);
      #1;
      check("upd_count", upd_cyc.size(), 5);
      if (upd_cyc.size() >= 5) begin
         for (int i = 0; i < 5; i++) check("upd_seq", upd_ph[i], i % 4);
         for (int i = 1; i < 5; i++) check("upd_spacing", upd_cyc[i] - upd_cyc[i-1], 15);
      end

      // Full-scale extremes, then the reference samples with spurious dones.
      do_frame(fa, fb, 5, 1'b0);
      do_frame(ra, rb, 5, 1'b1);

      // Timeout in phase 2, then a second timeout coinciding with clr_err.
      mv_before = mv_count + 1;
      run_phase(0, 11, 22, 3, 1'b0);
      run_phase(1, 33, 44, 3, 1'b0);
      hang(2, 1'b0, 0);
      hang(0, 1'b1, 1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_alone", adc_timeout, 0);

      // Abort during phase 1 SETTLE, then restart.
      phase_from_start(500, 500, 4, 1'b0);
      wait_update();
      check("abort_ph1", afe_phase, 1);
      repeat (3) step();
      enable = 1'b0;
      step();
      check("abort_busy", busy, 0);
      check("abort_hold_phase", afe_phase, 1);
      check("abort_no_update", afe_phase_update, 0);
      repeat (4) step();
      check("abort_stay_idle", busy, 0);
      check("abort_no_mv", mv_count, mv_before);
      enable = 1'b1;
      step();
      check("reenable_upd", afe_phase_update, 1);
      check("reenable_ph0", afe_phase, 0);
      do_frame(ta, tb, 2, 1'b0);

      // Reset in WAIT of phase 3.
      run_phase(0, 100, 100, 3, 1'b0);
      run_phase(1, 100, 100, 3, 1'b0);
      run_phase(2, 100, 100, 3, 1'b0);
      wait_update();
      check("rst3_phase", afe_phase, 3);
      wait_start();
      repeat (3) step();
      rst    = 1'b1;
      enable = 1'b0;
      step();
      check("rstw_afe_phase", afe_phase, 0);
      check("rstw_update", afe_phase_update, 0);
      check("rstw_start", adc_start, 0);
      check("rstw_meas_a", meas_a, 0);
      check("rstw_meas_b", meas_b, 0);
      check("rstw_meas_valid", meas_valid, 0);
      check("rstw_busy", busy, 0);
      check("rstw_timeout", adc_timeout, 0);
      rst = 1'b0;
      repeat (5) step();
      check("post_rst_meas_a", meas_a, 0);
      check("post_rst_busy", busy, 0);

      check("sb_drained", exp_a.size(), 0);
      check("mv_total", mv_count, frames);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hall_spin_demod.md
Name: hall_spin_demod

Overview:
Digital spinning-current sequencer and demodulator for the two Hall plates (A and B). It drives the AFE phase selection and the phase-update strobe, and launches one dual-channel ADC conversion per phase. Over a 4-phase frame it accumulates the samples with chopping signs, which cancels plate offset, and publishes one offset-free measurement per channel per frame. It sits between the AFE/ADC and the downstream digital sensor processing.

Parameters:
ADC_W, 12, width of each signed two's-complement ADC sample
SETTLE, 8, AFE settling cycles after each phase update (legal range: SETTLE >= 1)
TIMEOUT, 256, maximum cycles spent waiting for adc_done before the frame is aborted

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  synchronous reset, active-high
enable  in  1  level input; high = run frames continuously
clr_err  in  1  single-cycle pulse that clears adc_timeout
afe_phase  out  2  spinning-current phase index sent to the AFE
afe_phase_update  out  1  1-cycle strobe; the AFE applies afe_phase on this strobe
adc_start  out  1  1-cycle conversion request
adc_done  in  1  1-cycle pulse; adc_data_a and adc_data_b are valid in the same cycle
adc_data_a  in  ADC_W  signed sample, plate A
adc_data_b  in  ADC_W  signed sample, plate B
meas_a  out  ADC_W+2  signed demodulated frame sum, plate A
meas_b  out  ADC_W+2  signed demodulated frame sum, plate B
meas_valid  out  1  1-cycle pulse when meas_a and meas_b are updated
busy  out  1  high in every state except IDLE
adc_timeout  out  1  sticky error flag

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, accumulators 0, phase counter 0.
- FSM states: IDLE, UPDATE, SETTLE, START, WAIT.
- IDLE: enable sampled high at edge n -> UPDATE during cycle n+1.
- UPDATE (1 cycle): afe_phase = phase counter and afe_phase_update = 1. Then SETTLE.
- SETTLE: exactly SETTLE cycles, counted by a down-counter. Then START.
- START (1 cycle): adc_start = 1. Then WAIT.
- WAIT:
  - adc_done seen at an edge -> acc_a += s*adc_data_a and acc_b += s*adc_data_b, where s = +1 for phases 0 and 2 and s = -1 for phases 1 and 3.
  - Samples are sign-extended to ADC_W+2 bits before the add.
  - If phase < 3: increment the phase counter and go to UPDATE.
- Frame completion (adc_done in phase 3):
  - On the next cycle, meas_a and meas_b take the final sums and meas_valid = 1.
  - Accumulators clear and the phase counter returns to 0.
  - Go to UPDATE if enable = 1, otherwise IDLE.
  - meas_valid therefore coincides with the afe_phase_update for phase 0 of the next frame.
- Arithmetic: ADC_W+2 bits cannot overflow over 4 samples. Full range is -8190..+8190 for ADC_W = 12. No saturation and no scaling.
- meas_a and meas_b hold their value between meas_valid pulses.
- adc_done outside WAIT, including in the START cycle, is ignored.
- Timeout:
  - The WAIT cycle counter is reset on entry to WAIT.
  - TIMEOUT cycles in WAIT without adc_done -> adc_timeout is set (sticky), accumulators clear, phase counter returns to 0, then UPDATE (if enable) or IDLE.
  - No meas_valid is produced for an aborted frame.
- Error clearing: clr_err clears adc_timeout. If a set and a clear occur in the same cycle, set wins.
- enable low mid-frame:
  - Abort at the next edge: IDLE, accumulators and phase counter cleared, no meas_valid.
  - afe_phase holds its last value.
  - An adc_done coinciding with the abort edge is discarded.
- Frame period: 4 × (1 + SETTLE + 1 + Tw) + 0 cycles, where Tw counts WAIT cycles including the done cycle.
- rst mid-frame: every register returns to its reset value on that edge. Reset overrides all other inputs.

Test Plan:
- Basic frame: SETTLE=8, ADC done 5 cycles after start; samples A = 1000, -900, 1010, -890 and B = -50, 150, -60, 140 -> meas_a = 3800, meas_b = -400, one meas_valid, afe_phase sequence 0,1,2,3,0. Check exact strobe spacing of 1+8+1+5 cycles per phase.
- Full-scale extremes: A = 2047, -2048, 2047, -2048 -> meas_a = 8190; B = -2048, 2047, -2048, 2047 -> meas_b = -8190.
- Timeout: no adc_done in phase 2 for 256 cycles -> adc_timeout = 1, no meas_valid, frame restarts at phase 0. clr_err together with a second timeout in the same cycle -> flag stays 1; clr_err alone -> 0.
- Abort: enable dropped during phase 1 SETTLE -> IDLE next cycle, busy = 0, no meas_valid. Re-enable -> restart at phase 0 and produce correct sums.
- Spurious done: adc_done pulsed during SETTLE and during the START cycle -> ignored; accumulated result is unchanged versus the reference frame.
- Reset in WAIT of phase 3 -> all outputs 0 on the next cycle; meas_a and meas_b keep 0 rather than taking a partial result.
